issue_ctrl: RTL and testbench

ISSUE_CTRL -- requirements
Module: issue_ctrl

---
 rtl/issue_ctrl_pkg.sv | 38 +++
 rtl/issue_ctrl_decoder.sv | 18 +
 rtl/issue_ctrl.sv | 131 +++++++++++++
 tb/tb_issue_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_ctrl_pkg.sv
// Shared RV32I definitions for the issue stage: opcodes, FSM encodings and
// the per-opcode register-usage classification.
package issue_ctrl_pkg;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_READY = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;

    typedef struct packed {
        logic use_rs1;
        logic use_rs2;
        logic use_rd;
        logic illegal;
    } reg_use_t;

    function automatic reg_use_t classify(input logic [6:0] type_code);
        reg_use_t u;
        case (type_code)
            OP_OP:                    u = '{1'b1, 1'b1, 1'b1, 1'b0};
            OP_IMM, OP_LOAD, OP_JALR: u = '{1'b1, 1'b0, 1'b1, 1'b0};
            OP_STORE, OP_BRANCH:      u = '{1'b1, 1'b1, 1'b0, 1'b0};
            OP_LUI, OP_AUIPC, OP_JAL: u = '{1'b0, 1'b0, 1'b1, 1'b0};
            default:                  u = '{1'b0, 1'b0, 1'b0, 1'b1};
        endcase
        return u;
    endfunction

endpackage

// File: rtl/issue_ctrl_decoder.sv
// Combinational RV32I field extraction feeding the issue holding register.
module issue_ctrl_decoder (
    input  logic [31:0] instr,
    output logic [6:0]  type_code,
    output logic [9:0]  alu_op,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd
);

    assign type_code = instr[6:0];
    // funct7 and funct3 together fully identify the ALU operation
    assign alu_op    = {instr[31:25], instr[14:12]};
    assign rs1       = instr[19:15];
    assign rs2       = instr[24:20];
    assign rd        = instr[11:7];

endmodule

// File: rtl/issue_ctrl.sv
// Single-entry issue stage with a busy-bit scoreboard that blocks RAW/WAW
// hazards until the producing write retires.
module issue_ctrl
    import issue_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic        flush,
    output logic        iss_valid,
    input  logic        iss_ready,
    output logic [6:0]  iss_type_code,
    output logic [9:0]  iss_alu_op,
    output logic [4:0]  iss_rs1,
    output logic [4:0]  iss_rs2,
    output logic [4:0]  iss_rd,
    output logic        iss_illegal,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    output logic [31:0] busy_mask,
    output logic [15:0] stall_cnt
);

    logic [6:0]  dec_type;
    logic [9:0]  dec_alu_op;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    reg_use_t    dec_use;

    logic [1:0]  state_reg, state_next;
    logic [6:0]  type_reg;
    logic [9:0]  alu_op_reg;
    logic [4:0]  rs1_reg, rs2_reg, rd_reg;
    reg_use_t    use_reg;
    logic [31:0] busy_reg, busy_next, set_vec;
    logic [15:0] stall_reg;

    logic accept, fire, hazard_d, hazard_new;

    issue_ctrl_decoder u_decoder (
        .instr     (instr),
        .type_code (dec_type),
        .alu_op    (dec_alu_op),
        .rs1       (dec_rs1),
        .rs2       (dec_rs2),
        .rd        (dec_rd)
    );

    assign dec_use = classify(dec_type);

    function automatic logic hazard_of(input reg_use_t u, input logic [4:0] r1,
                                       input logic [4:0] r2, input logic [4:0] rd,
                                       input logic [31:0] mask);
        return (u.use_rs1 & mask[r1]) | (u.use_rs2 & mask[r2]) | (u.use_rd & mask[rd]);
    endfunction

    assign iss_valid = (state_reg == ST_READY);
    assign in_ready  = ~flush & ((state_reg == ST_EMPTY) | (iss_valid & iss_ready));
    assign accept    = in_valid & in_ready;
    assign fire      = iss_valid & iss_ready & ~flush;

    // x0 is hard-wired idle; for other registers a same-cycle set beats a clear
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_busy
            if (gi == 0) begin : g_x0
                assign set_vec[gi]   = 1'b0;
                assign busy_next[gi] = 1'b0;
            end else begin : g_reg
                assign set_vec[gi]   = fire & use_reg.use_rd & (rd_reg == 5'(gi));
                assign busy_next[gi] = set_vec[gi] |
                                       (busy_reg[gi] & ~(wb_valid & (wb_rd == 5'(gi))));
            end
        end
    endgenerate

    assign hazard_d   = hazard_of(use_reg, rs1_reg, rs2_reg, rd_reg, busy_reg);
    // Incoming instruction sees the producer firing this cycle but not a retiring write
    assign hazard_new = hazard_of(dec_use, dec_rs1, dec_rs2, dec_rd, busy_reg | set_vec);

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = ST_EMPTY;
        end else if (accept) begin
            state_next = hazard_new ? ST_STALL : ST_READY;
        end else if (fire) begin
            state_next = ST_EMPTY;
        end else if (state_reg == ST_STALL) begin
            state_next = hazard_d ? ST_STALL : ST_READY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_EMPTY;
            type_reg   <= '0;
            alu_op_reg <= '0;
            rs1_reg    <= '0;
            rs2_reg    <= '0;
            rd_reg     <= '0;
            use_reg    <= '0;
            busy_reg   <= '0;
            stall_reg  <= '0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= busy_next;
            if (accept) begin
                type_reg   <= dec_type;
                alu_op_reg <= dec_alu_op;
                rs1_reg    <= dec_rs1;
                rs2_reg    <= dec_rs2;
                rd_reg     <= dec_rd;
                use_reg    <= dec_use;
            end
            if ((state_reg == ST_STALL) && (stall_reg != 16'hFFFF)) begin
                stall_reg <= stall_reg + 16'd1;
            end
        end
    end

    assign iss_type_code = type_reg;
    assign iss_alu_op    = alu_op_reg;
    assign iss_rs1       = rs1_reg;
    assign iss_rs2       = rs2_reg;
    assign iss_rd        = rd_reg;
    assign iss_illegal   = use_reg.illegal;
    assign busy_mask     = busy_reg;
    assign stall_cnt     = stall_reg;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed scenarios followed by a randomized stream checked against a
// queue-based model of the in-order issue stage and its scoreboard.
module tb_issue_ctrl;

    localparam logic [31:0] SUB   = 32'h401101B3; // sub  x3,x2,x1
    localparam logic [31:0] ADD   = 32'h00018233; // add  x4,x3,x0
    localparam logic [31:0] OR9   = 32'h0020E4B3; // or   x9,x1,x2
    localparam logic [31:0] SLT   = 32'h00C3A0B3; // slt  x1,x7,x12
    localparam logic [31:0] ADDI5 = 32'h00100293; // addi x5,x0,1
    localparam logic [31:0] ADD6  = 32'h00028333; // add  x6,x5,x0
    localparam logic [31:0] ADDI7 = 32'h00100393; // addi x7,x0,1

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, flush, iss_valid, iss_ready;
    logic        iss_illegal, wb_valid;
    logic [31:0] instr, busy_mask;
    logic [6:0]  iss_type_code;
    logic [9:0]  iss_alu_op;
    logic [4:0]  iss_rs1, iss_rs2, iss_rd, wb_rd;
    logic [15:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    logic [31:0] q[$];
    logic [31:0] m_busy, h;
    logic        exp_ready, fire;
    int          wait_cnt;

    always #5 clk = ~clk;

    issue_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instr         (instr),
        .flush         (flush),
        .iss_valid     (iss_valid),
        .iss_ready     (iss_ready),
        .iss_type_code (iss_type_code),
        .iss_alu_op    (iss_alu_op),
        .iss_rs1       (iss_rs1),
        .iss_rs2       (iss_rs2),
        .iss_rd        (iss_rd),
        .iss_illegal   (iss_illegal),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .busy_mask     (busy_mask),
        .stall_cnt     (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    function automatic bit uses_rs1(input logic [31:0] w);
        case (w[6:0])
            7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit uses_rs2(input logic [31:0] w);
        case (w[6:0])
            7'h33, 7'h23, 7'h63: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit uses_rd(input logic [31:0] w);
        case (w[6:0])
            7'h33, 7'h13, 7'h03, 7'h67, 7'h37, 7'h17, 7'h6F: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit is_illegal(input logic [31:0] w);
        return !(uses_rs1(w) || uses_rd(w));
    endfunction

    function automatic bit m_hazard(input logic [31:0] w, input logic [31:0] mask);
        return (uses_rs1(w) && mask[w[19:15]]) || (uses_rs2(w) && mask[w[24:20]]) ||
               (uses_rd(w) && mask[w[11:7]]);
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63,
                                 7'h37, 7'h17, 7'h6F, 7'h7F};
        return {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                3'($urandom), 5'($urandom_range(0, 7)), ops[$urandom_range(0, 9)]};
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; instr = '0; flush = 1'b0;
        iss_ready = 1'b0; wb_valid = 1'b0; wb_rd = '0;
        repeat (2) @(posedge clk);
        samp();
        chk("rst_iss_valid", iss_valid, 0);
        chk("rst_busy", busy_mask, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_iss_rd", iss_rd, 0);
        chk("rst_illegal", iss_illegal, 0);
        step(); rst_n = 1'b1; samp();
        chk("post_rst_in_ready", in_ready, 1);
        $display("reset: busy=%h stall=%0d", busy_mask, stall_cnt);

        // Independent stream: three back-to-back issues
        step(); in_valid = 1; instr = SUB; iss_ready = 1; samp();
        chk("ind_accept_ready", in_ready, 1);
        step(); instr = OR9; samp();
        chk("ind0_valid", iss_valid, 1);
        chk("ind0_rs1", iss_rs1, 2); chk("ind0_rs2", iss_rs2, 1); chk("ind0_rd", iss_rd, 3);
        chk("ind0_alu", iss_alu_op, 10'h100); chk("ind0_type", iss_type_code, 7'h33);
        chk("ind0_in_ready", in_ready, 1);
        step(); instr = SLT; samp();
        chk("ind1_valid", iss_valid, 1);
        chk("ind1_rs1", iss_rs1, 1); chk("ind1_rs2", iss_rs2, 2); chk("ind1_rd", iss_rd, 9);
        chk("ind1_busy", busy_mask, 32'h8);
        step(); in_valid = 0; samp();
        chk("ind2_valid", iss_valid, 1);
        chk("ind2_rs1", iss_rs1, 7); chk("ind2_rs2", iss_rs2, 12); chk("ind2_rd", iss_rd, 1);
        step(); samp();
        chk("ind_done_valid", iss_valid, 0);
        chk("ind_busy", busy_mask, 32'h20A);
        $display("independent: busy=%h", busy_mask);
        foreach (q[i]) q.delete(i);
        step(); wb_valid = 1; wb_rd = 1; samp();
        step(); wb_rd = 3; samp();
        step(); wb_rd = 9; samp();
        step(); wb_valid = 0; samp();
        chk("ind_wb_clear", busy_mask, 0);

        // RAW: add waits on sub's x3 until the write retires
        step(); in_valid = 1; instr = SUB; samp();
        step(); instr = ADD; samp();
        chk("raw_sub_valid", iss_valid, 1);
        chk("raw_add_accept", in_ready, 1);
        step(); in_valid = 0; samp();
        chk("raw_stall0", iss_valid, 0);
        chk("raw_busy3", busy_mask, 32'h8);
        chk("raw_in_ready", in_ready, 0);
        for (int i = 1; i < 3; i++) begin
            step(); samp();
            chk("raw_stall_wait", iss_valid, 0);
        end
        step(); wb_valid = 1; wb_rd = 3; samp();
        chk("raw_wb_cycle", iss_valid, 0);
        step(); wb_valid = 0; samp();
        chk("raw_wb_plus1", iss_valid, 0);
        chk("raw_busy_cleared", busy_mask, 0);
        step(); samp();
        chk("raw_issue", iss_valid, 1);
        chk("raw_rs1", iss_rs1, 3); chk("raw_rd", iss_rd, 4);
        chk("raw_stall_cnt", stall_cnt, 5); // 3 waiting + wb cycle + clear cycle
        step(); samp();
        chk("raw_busy4", busy_mask, 32'h10);
        $display("raw: stall_cnt=%0d busy=%h", stall_cnt, busy_mask);
        step(); wb_valid = 1; wb_rd = 4; samp();
        step(); wb_valid = 0; samp();
        chk("raw_wb4_clear", busy_mask, 0);

        // Same-cycle set and clear on x5
        step(); in_valid = 1; instr = ADDI5; samp();
        step(); in_valid = 0; wb_valid = 1; wb_rd = 5; samp();
        chk("sc_issue", iss_valid, 1);
        chk("sc_rd", iss_rd, 5);
        step(); wb_valid = 0; samp();
        chk("sc_set_wins", busy_mask, 32'h20);
        $display("set/clear: busy=%h", busy_mask);

        // Flush while stalled on x5
        step(); in_valid = 1; instr = ADD6; samp();
        chk("fl_accept", in_ready, 1);
        step(); in_valid = 0; samp();
        chk("fl_stalled", iss_valid, 0);
        step(); flush = 1; samp();
        chk("fl_in_ready", in_ready, 0);
        step(); flush = 0; samp();
        chk("fl_empty", in_ready, 1);
        chk("fl_valid", iss_valid, 0);
        chk("fl_busy", busy_mask, 32'h20);
        chk("fl_stall_cnt", stall_cnt, 7);
        // Flush in the same cycle as an issue fire suppresses the fire
        step(); in_valid = 1; instr = ADDI7; iss_ready = 1; samp();
        step(); in_valid = 0; flush = 1; samp();
        chk("flr_valid", iss_valid, 1);
        chk("flr_in_ready", in_ready, 0);
        step(); flush = 0; samp();
        chk("flr_gone", iss_valid, 0);
        chk("flr_busy", busy_mask, 32'h20);
        $display("flush: busy=%h stall_cnt=%0d", busy_mask, stall_cnt);
        step(); wb_valid = 1; wb_rd = 5; samp();
        step(); wb_valid = 0; samp();
        chk("fl_wb5_clear", busy_mask, 0);

        // Illegal opcodes issue without touching the scoreboard
        step(); in_valid = 1; instr = 32'h0000007F; samp();
        step(); instr = 32'h00000FFF; samp();
        chk("ill0_valid", iss_valid, 1);
        chk("ill0_flag", iss_illegal, 1);
        step(); in_valid = 0; samp();
        chk("ill1_flag", iss_illegal, 1);
        chk("ill1_rd", iss_rd, 31);
        chk("ill1_busy", busy_mask, 0);
        step(); samp();
        chk("ill_busy_after", busy_mask, 0);
        $display("illegal: busy=%h", busy_mask);

        // Backpressure: held instruction stays stable until it fires
        step(); in_valid = 1; instr = SUB; iss_ready = 0; samp();
        for (int i = 0; i < 3; i++) begin
            step(); instr = OR9; samp();
            chk("bp_valid", iss_valid, 1);
            chk("bp_rs1", iss_rs1, 2);
            chk("bp_rd", iss_rd, 3);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_busy", busy_mask, 0);
        end
        step(); iss_ready = 1; samp();
        chk("bp_fire_ready", in_ready, 1);
        chk("bp_fire_rd", iss_rd, 3);
        step(); in_valid = 0; samp();
        chk("bp_busy3", busy_mask, 32'h8);
        chk("bp_next_rd", iss_rd, 9);
        step(); samp();
        chk("bp_busy_both", busy_mask, 32'h208);
        $display("backpressure: busy=%h", busy_mask);

        // Asynchronous reset in the middle of a stall
        step(); in_valid = 1; instr = ADD; samp();
        step(); in_valid = 0; samp();
        chk("mr_stalled", iss_valid, 0);
        step(); samp();
        chk("mr_stall_cnt", stall_cnt, 8);
        rst_n = 0; #1;
        chk("mr_valid", iss_valid, 0);
        chk("mr_busy", busy_mask, 0);
        chk("mr_stall", stall_cnt, 0);
        chk("mr_in_ready", in_ready, 1);
        step(); rst_n = 1; samp();
        chk("mr_post_ready", in_ready, 1);
        chk("mr_post_busy", busy_mask, 0);
        $display("mid reset: busy=%h stall=%0d", busy_mask, stall_cnt);

        // Randomized stream against the queue model
        m_busy = '0; wait_cnt = 0;
        for (int k = 0; k < 400; k++) begin
            step();
            in_valid  = ($urandom_range(0, 3) != 0);
            instr     = rnd_instr();
            iss_ready = ($urandom_range(0, 3) != 0);
            wb_valid  = ($urandom_range(0, 2) == 0);
            wb_rd     = 5'($urandom_range(0, 7));
            flush     = ($urandom_range(0, 19) == 0);
            samp();
            exp_ready = !flush && ((q.size() == 0) || (iss_valid && iss_ready));
            chk("rnd_in_ready", in_ready, exp_ready);
            chk("rnd_busy", busy_mask, m_busy);
            if (q.size() == 0) begin
                chk("rnd_idle", iss_valid, 0);
            end else begin
                h = q[0];
                if (m_hazard(h, m_busy)) begin
                    chk("rnd_hazard_hold", iss_valid, 0);
                    wait_cnt = 0;
                end else if (!iss_valid) begin
                    wait_cnt++;
                    chk("rnd_latency", (wait_cnt <= 1), 1);
                end
                if (iss_valid) begin
                    chk("rnd_type", iss_type_code, h[6:0]);
                    chk("rnd_rs1", iss_rs1, h[19:15]);
                    chk("rnd_rs2", iss_rs2, h[24:20]);
                    chk("rnd_rd", iss_rd, h[11:7]);
                    chk("rnd_illegal", iss_illegal, is_illegal(h));
                end
            end
            $display("rnd %0d: in_v=%0d instr=%h iss_v=%0d busy=%h q=%0d", k, in_valid,
                     instr, iss_valid, busy_mask, q.size());
            fire = iss_valid && iss_ready && !flush && (q.size() > 0);
            if (wb_valid && (wb_rd != 0)) m_busy[wb_rd] = 1'b0;
            if (fire) begin
                h = q.pop_front();
                if (uses_rd(h) && (h[11:7] != 0)) m_busy[h[11:7]] = 1'b1;
                wait_cnt = 0;
            end
            if (flush) begin
                q.delete();
                wait_cnt = 0;
            end else if (in_valid && exp_ready) begin
                q.push_back(instr);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
